// File: rtl/prog_run_ctrl.sv
// Run controller between the host and the processor core.
// It selects a program entry point and holds the core in reset while the PC is
// loaded. It then releases the core and counts RUN cycles. The run finishes
// when the core halts or when the watchdog expires.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | core held in reset, waiting for a start request
// LOAD   | one cycle: core still in reset, pc_load strobe to the core
// RUN    | core released, cycle counter and watchdog active
// DONE   | core held in reset, results (count, timeout) held for host
module prog_run_ctrl #(
    parameter int PC_W       = 10,
    parameter int CNT_W      = 16,
    parameter int MAX_CYCLES = 50000,
    parameter int BASE0      = 0,
    parameter int BASE1      = 0,
    parameter int BASE2      = 256,
    parameter int BASE3      = 512
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req,
    input  logic [1:0]       prog_sel,
    input  logic             halt,
    output logic             core_rst,
    output logic             pc_load,
    output logic [PC_W-1:0]  pc_start,
    output logic             busy,
    output logic             done,
    output logic             timeout,
    output logic [CNT_W-1:0] cycle_count
);

    localparam logic [CNT_W-1:0] LIMIT  = CNT_W'(MAX_CYCLES);
    localparam logic [PC_W-1:0]  BASE_0 = PC_W'(BASE0);
    localparam logic [PC_W-1:0]  BASE_1 = PC_W'(BASE1);
    localparam logic [PC_W-1:0]  BASE_2 = PC_W'(BASE2);
    localparam logic [PC_W-1:0]  BASE_3 = PC_W'(BASE3);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           state, state_nxt;
    logic [PC_W-1:0]  pc_start_nxt;
    logic [CNT_W-1:0] cycle_count_nxt;
    logic             timeout_nxt;
    // The watchdog counts down the RUN cycles that remain. The run expires
    // when the count is 1 during a RUN cycle, so the run ends exactly on
    // cycle LIMIT.
    logic [CNT_W-1:0] wd_left, wd_left_nxt;
    logic             core_rst_nxt, pc_load_nxt, busy_nxt, done_nxt;
    logic [PC_W-1:0]  base_sel;

    // Map the program select input to its entry address.
    always_comb begin
        base_sel = BASE_0;
        case (prog_sel)
            2'd0: base_sel = BASE_0;
            2'd1: base_sel = BASE_1;
            2'd2: base_sel = BASE_2;
            2'd3: base_sel = BASE_3;
            default: base_sel = BASE_0;
        endcase
    end

    // Compute the next state and the next datapath values. The outputs are
    // derived from the next state so that they come straight from registers.
    always_comb begin
        state_nxt       = state;
        pc_start_nxt    = pc_start;
        cycle_count_nxt = cycle_count;
        timeout_nxt     = timeout;
        wd_left_nxt     = wd_left;

        case (state)
            S_IDLE, S_DONE: begin
                if (req) begin
                    state_nxt       = S_LOAD;
                    pc_start_nxt    = base_sel;
                    cycle_count_nxt = '0;
                    timeout_nxt     = 1'b0;
                    wd_left_nxt     = LIMIT;
                end
            end
            S_LOAD: begin
                state_nxt = S_RUN;
            end
            S_RUN: begin
                cycle_count_nxt = cycle_count + 1'b1;
                wd_left_nxt     = wd_left - 1'b1;
                // If halt and the limit occur together, the halt takes
                // priority and the run counts as a clean finish.
                if (halt) begin
                    state_nxt   = S_DONE;
                    timeout_nxt = 1'b0;
                end else if (wd_left == CNT_W'(1)) begin
                    state_nxt   = S_DONE;
                    timeout_nxt = 1'b1;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        core_rst_nxt = (state_nxt != S_RUN);
        pc_load_nxt  = (state_nxt == S_LOAD);
        busy_nxt     = (state_nxt == S_LOAD) || (state_nxt == S_RUN);
        done_nxt     = (state_nxt == S_DONE);
    end

    // State and output registers. The reset takes effect immediately, even in
    // the middle of a run.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            pc_start    <= '0;
            cycle_count <= '0;
            timeout     <= 1'b0;
            wd_left     <= '0;
            core_rst    <= 1'b1;
            pc_load     <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_nxt;
            pc_start    <= pc_start_nxt;
            cycle_count <= cycle_count_nxt;
            timeout     <= timeout_nxt;
            wd_left     <= wd_left_nxt;
            core_rst    <= core_rst_nxt;
            pc_load     <= pc_load_nxt;
            busy        <= busy_nxt;
            done        <= done_nxt;
        end
    end

endmodule

// File: tb/tb_prog_run_ctrl.sv
// Testbench for prog_run_ctrl. It applies a table of per-cycle vectors, then
// runs hand-written sequences for the watchdog, a halt on the limit cycle, and
// a reset in the middle of a run.
module tb_prog_run_ctrl;

    localparam int PC_W  = 10;
    localparam int CNT_W = 16;
    localparam int LIMIT = 20;

    logic             clk;
    logic             reset;
    logic             req;
    logic [1:0]       prog_sel;
    logic             halt;
    logic             core_rst;
    logic             pc_load;
    logic [PC_W-1:0]  pc_start;
    logic             busy;
    logic             done;
    logic             timeout;
    logic [CNT_W-1:0] cycle_count;

    int n_tests = 0;
    int n_fail  = 0;

    prog_run_ctrl #(
        .PC_W(PC_W), .CNT_W(CNT_W), .MAX_CYCLES(LIMIT),
        .BASE0(0), .BASE1(0), .BASE2(256), .BASE3(512)
    ) dut (
        .clk(clk), .reset(reset), .req(req), .prog_sel(prog_sel), .halt(halt),
        .core_rst(core_rst), .pc_load(pc_load), .pc_start(pc_start),
        .busy(busy), .done(done), .timeout(timeout), .cycle_count(cycle_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stop the run if it never reaches the summary line.
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1, "time limit reached");
    end

    typedef struct {
        logic        req;
        logic [1:0]  sel;
        logic        halt;
        logic        cr;
        logic        pl;
        int          pcs;
        logic        busy;
        logic        done;
        logic        to;
        int          cnt;
    } vec_t;

    vec_t vecs[17];

    function automatic vec_t mk(input logic r, input logic [1:0] s, input logic h,
                                input logic cr, input logic pl, input int pcs,
                                input logic b, input logic d, input logic t, input int c);
        vec_t v;
        v.req = r; v.sel = s; v.halt = h;
        v.cr = cr; v.pl = pl; v.pcs = pcs; v.busy = b; v.done = d; v.to = t; v.cnt = c;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic cr, input logic pl, input int pcs,
                             input logic b, input logic d, input logic t, input int c);
        check({tag, ".core_rst"},    int'(core_rst),    int'(cr));
        check({tag, ".pc_load"},     int'(pc_load),     int'(pl));
        check({tag, ".pc_start"},    int'(pc_start),    pcs);
        check({tag, ".busy"},        int'(busy),        int'(b));
        check({tag, ".done"},        int'(done),        int'(d));
        check({tag, ".timeout"},     int'(timeout),     int'(t));
        check({tag, ".cycle_count"}, int'(cycle_count), c);
    endtask

    // Accept a request. The task checks the LOAD cycle and leaves the DUT at
    // the start of RUN with cycle_count at 0.
    task automatic run_start(input logic [1:0] sel, input int exp_pcs, input string tag);
        @(negedge clk);
        req = 1'b1; prog_sel = sel; halt = 1'b0;
        @(posedge clk); #1;
        check_all({tag, ".load"}, 1'b1, 1'b1, exp_pcs, 1'b1, 1'b0, 1'b0, 0);
        @(negedge clk);
        req = 1'b0;
        @(posedge clk); #1;
        check_all({tag, ".run0"}, 1'b0, 1'b0, exp_pcs, 1'b1, 1'b0, 1'b0, 0);
    endtask

    initial begin
        //          req sel halt | cr pl pcs  busy done to cnt
        vecs[0]  = mk(0, 0, 1,     1, 0,   0, 0, 0, 0, 0); // halt in IDLE ignored
        vecs[1]  = mk(1, 3, 0,     1, 1, 512, 1, 0, 0, 0); // accept, LOAD
        vecs[2]  = mk(0, 0, 1,     0, 0, 512, 1, 0, 0, 0); // halt in LOAD ignored
        vecs[3]  = mk(0, 0, 0,     0, 0, 512, 1, 0, 0, 1);
        vecs[4]  = mk(1, 1, 0,     0, 0, 512, 1, 0, 0, 2); // req in RUN ignored
        vecs[5]  = mk(1, 1, 0,     0, 0, 512, 1, 0, 0, 3);
        vecs[6]  = mk(0, 0, 0,     0, 0, 512, 1, 0, 0, 4);
        vecs[7]  = mk(0, 0, 1,     1, 0, 512, 0, 1, 0, 5); // halt on 5th cycle
        vecs[8]  = mk(0, 2, 1,     1, 0, 512, 0, 1, 0, 5); // DONE holds
        vecs[9]  = mk(1, 2, 0,     1, 1, 256, 1, 0, 0, 0); // req from DONE
        vecs[10] = mk(0, 0, 0,     0, 0, 256, 1, 0, 0, 0);
        vecs[11] = mk(0, 0, 1,     1, 0, 256, 0, 1, 0, 1); // halt on 1st cycle
        vecs[12] = mk(1, 0, 0,     1, 1,   0, 1, 0, 0, 0);
        vecs[13] = mk(0, 3, 0,     0, 0,   0, 1, 0, 0, 0); // sel change ignored
        vecs[14] = mk(0, 3, 0,     0, 0,   0, 1, 0, 0, 1);
        vecs[15] = mk(0, 0, 1,     1, 0,   0, 0, 1, 0, 2);
        vecs[16] = mk(0, 0, 0,     1, 0,   0, 0, 1, 0, 2);

        reset = 1'b0; req = 1'b0; prog_sel = 2'd0; halt = 1'b0;

        // Check the reset state, then the idle state after reset is released.
        repeat (2) @(posedge clk);
        #1;
        check_all("reset", 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0, 0);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_all("idle", 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0, 0);

        // Table vectors: drive the inputs on the falling edge and check the
        // outputs just after the next rising edge.
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            req = vecs[i].req; prog_sel = vecs[i].sel; halt = vecs[i].halt;
            @(posedge clk); #1;
            check_all($sformatf("vec%0d", i), vecs[i].cr, vecs[i].pl, vecs[i].pcs,
                      vecs[i].busy, vecs[i].done, vecs[i].to, vecs[i].cnt);
        end

        // Watchdog expiry with no halt.
        run_start(2'd1, 0, "wd");
        for (int k = 1; k <= LIMIT; k++) begin
            @(posedge clk); #1;
            if (k == LIMIT - 1)
                check_all("wd.pre", 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0, LIMIT - 1);
        end
        check_all("wd.end", 1'b1, 1'b0, 0, 1'b0, 1'b1, 1'b1, LIMIT);
        @(posedge clk); #1;
        check_all("wd.hold", 1'b1, 1'b0, 0, 1'b0, 1'b1, 1'b1, LIMIT);

        // Halt on the same cycle as the limit. The halt takes priority.
        run_start(2'd2, 256, "co");
        for (int k = 1; k <= LIMIT; k++) begin
            @(negedge clk);
            halt = (k == LIMIT);
            @(posedge clk); #1;
        end
        check_all("co.end", 1'b1, 1'b0, 256, 1'b0, 1'b1, 1'b0, LIMIT);
        @(negedge clk);
        halt = 1'b0;

        // Reset asserted in the middle of a run.
        run_start(2'd3, 512, "mr");
        repeat (7) @(posedge clk);
        #1;
        check_all("mr.cyc7", 1'b0, 1'b0, 512, 1'b1, 1'b0, 1'b0, 7);
        #2;
        reset = 1'b0;
        #1;
        check_all("mr.async", 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0, 0);
        @(negedge clk);
        reset = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check_all("mr.idle", 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0, 0);
        run_start(2'd2, 256, "mr.fresh");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
